// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder: validates received frames, tracks prefixes and shift,
// translates a fixed key subset to ASCII and queues it for CPU reads on the 64-bit bus.
module ps2_scancode_decoder #(
    parameter logic [13:0] KBD_ADDRESS = 14'h2500,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        system_clk,
    input  logic        reset,
    input  logic        frame_valid,
    input  logic [10:0] frame,
    input  logic [13:0] address,
    input  logic        read,
    output logic [63:0] data
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BREAK,
        S_EXT,
        S_EXT_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          shift_q, shift_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          frame_err_q, frame_err_d;
    logic          read_hit_q;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic [7:0] rx_byte;
    logic       frame_ok;
    logic       is_shift_key;
    logic       map_hit;
    logic [7:0] map_ascii;
    logic       push;
    logic [7:0] push_data;
    logic       bad_frame;
    logic       read_match;
    logic       pop_edge;
    logic       fifo_empty;
    logic       fifo_full;
    logic       pop_do;
    logic       push_ok;
    logic [7:0] head_ascii;

    assign rx_byte      = frame[8:1];
    assign frame_ok     = (frame[0] == 1'b0) && (frame[10] == 1'b1) && (^frame[9:1] == 1'b1);
    assign is_shift_key = (rx_byte == SC_LSHIFT) || (rx_byte == SC_RSHIFT);

    // Scancode to ASCII; letters are shifted to uppercase, digits and controls are not.
    always_comb begin
        logic letter;
        letter    = 1'b1;
        map_hit   = 1'b1;
        map_ascii = 8'h00;
        unique case (rx_byte)
            8'h1C: map_ascii = 8'h61; // a
            8'h32: map_ascii = 8'h62;
            8'h21: map_ascii = 8'h63;
            8'h23: map_ascii = 8'h64;
            8'h24: map_ascii = 8'h65;
            8'h2B: map_ascii = 8'h66;
            8'h34: map_ascii = 8'h67;
            8'h33: map_ascii = 8'h68;
            8'h43: map_ascii = 8'h69;
            8'h3B: map_ascii = 8'h6A;
            8'h42: map_ascii = 8'h6B;
            8'h4B: map_ascii = 8'h6C;
            8'h3A: map_ascii = 8'h6D;
            8'h31: map_ascii = 8'h6E;
            8'h44: map_ascii = 8'h6F;
            8'h4D: map_ascii = 8'h70;
            8'h15: map_ascii = 8'h71;
            8'h2D: map_ascii = 8'h72;
            8'h1B: map_ascii = 8'h73;
            8'h2C: map_ascii = 8'h74;
            8'h3C: map_ascii = 8'h75;
            8'h2A: map_ascii = 8'h76;
            8'h1D: map_ascii = 8'h77;
            8'h22: map_ascii = 8'h78;
            8'h35: map_ascii = 8'h79;
            8'h1A: map_ascii = 8'h7A; // z
            8'h45: begin map_ascii = 8'h30; letter = 1'b0; end
            8'h16: begin map_ascii = 8'h31; letter = 1'b0; end
            8'h1E: begin map_ascii = 8'h32; letter = 1'b0; end
            8'h26: begin map_ascii = 8'h33; letter = 1'b0; end
            8'h25: begin map_ascii = 8'h34; letter = 1'b0; end
            8'h2E: begin map_ascii = 8'h35; letter = 1'b0; end
            8'h36: begin map_ascii = 8'h36; letter = 1'b0; end
            8'h3D: begin map_ascii = 8'h37; letter = 1'b0; end
            8'h3E: begin map_ascii = 8'h38; letter = 1'b0; end
            8'h46: begin map_ascii = 8'h39; letter = 1'b0; end
            8'h29: begin map_ascii = 8'h20; letter = 1'b0; end
            8'h5A: begin map_ascii = 8'h0D; letter = 1'b0; end
            8'h66: begin map_ascii = 8'h08; letter = 1'b0; end
            default: begin map_hit = 1'b0; letter = 1'b0; end
        endcase
        if (letter && shift_q) begin
            map_ascii = map_ascii - 8'h20;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        push      = 1'b0;
        push_data = 8'h00;
        bad_frame = 1'b0;
        if (frame_valid) begin
            if (!frame_ok) begin
                bad_frame = 1'b1;
                state_d   = S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (rx_byte == SC_BREAK) begin
                            state_d = S_BREAK;
                        end else if (rx_byte == SC_EXT) begin
                            state_d = S_EXT;
                        end else if (is_shift_key) begin
                            shift_d = 1'b1;
                        end else if (map_hit) begin
                            push      = 1'b1;
                            push_data = map_ascii;
                        end
                    end
                    S_BREAK: begin
                        if (is_shift_key) begin
                            shift_d = 1'b0;
                        end
                        state_d = S_IDLE;
                    end
                    S_EXT: begin
                        state_d = (rx_byte == SC_BREAK) ? S_EXT_BREAK : S_IDLE;
                    end
                    S_EXT_BREAK: begin
                        state_d = S_IDLE;
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    assign read_match = (address == KBD_ADDRESS) && read;
    assign pop_edge   = read_match && !read_hit_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);
    // An empty FIFO never pops, so a same-cycle push into it simply lands.
    assign pop_do     = pop_edge && !fifo_empty;
    assign push_ok    = push && (!fifo_full || pop_do);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        frame_err_d = frame_err_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_do) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_do) begin
            count_d = count_q + 1'b1;
        end else if (pop_do && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        // Clear on the read edge first so a same-cycle set wins.
        if (pop_edge) begin
            overflow_d  = 1'b0;
            frame_err_d = 1'b0;
        end
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (bad_frame) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shift_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            read_hit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            read_hit_q  <= read_match;
        end
    end

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_ascii = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign data = read_match ? {53'b0, frame_err_q, overflow_q, !fifo_empty, head_ascii} : 'z;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: hand-computed bus read values after frame sequences.
module tb_ps2_scancode_decoder;

    localparam logic [13:0] KBD = 14'h2500;

    logic        clk;
    logic        rst;
    logic        fv;
    logic [10:0] fr;
    logic [13:0] addr;
    logic        rd;
    logic [63:0] data_w;

    int errors = 0;
    int checks = 0;

    ps2_scancode_decoder #(.KBD_ADDRESS(14'h2500), .FIFO_DEPTH(8)) dut (
        .system_clk (clk),
        .reset      (rst),
        .frame_valid(fv),
        .frame      (fr),
        .address    (addr),
        .read       (rd),
        .data       (data_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    // Each call drives one frame for one cycle; consecutive calls are back-to-back.
    task automatic send(input logic [7:0] b);
        fv = 1'b1;
        fr = mk(b);
        @(negedge clk);
        fv = 1'b0;
    endtask

    task automatic send_raw(input logic [10:0] f);
        fv = 1'b1;
        fr = f;
        @(negedge clk);
        fv = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [63:0] exp);
        addr = KBD;
        rd   = 1'b1;
        #1 check(tag, data_w, exp);
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [10:0] f;
        rst  = 1'b1;
        fv   = 1'b0;
        fr   = '0;
        addr = '0;
        rd   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        bus_read("reset_read", 64'h0);

        send(8'h1C); send(8'hF0); send(8'h1C);
        bus_read("make_a", 64'h161);
        bus_read("make_a_empty", 64'h0);

        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
        bus_read("shift_A", 64'h141);
        bus_read("unshift_a", 64'h161);
        bus_read("shift_empty", 64'h0);

        f = mk(8'h1C);
        f[9] = ~f[9];
        send_raw(f);
        bus_read("parity_err", 64'h400);
        bus_read("parity_err_clr", 64'h0);

        send(8'hF0);
        f = mk(8'h1C);
        f[0] = 1'b1;
        send_raw(f);
        send(8'h1C);
        bus_read("start_err_then_a", 64'h561);
        bus_read("start_err_clr", 64'h0);

        for (int i = 0; i < 9; i++) send(8'h16);
        bus_read("ovf_first", 64'h331);
        for (int i = 0; i < 7; i++) bus_read("ovf_rest", 64'h131);
        bus_read("ovf_empty", 64'h0);

        // Full FIFO: push and read edge in the same cycle.
        for (int i = 0; i < 8; i++) send(8'h16);
        fv   = 1'b1;
        fr   = mk(8'h1C);
        addr = KBD;
        rd   = 1'b1;
        #1 check("full_pushpop_pre", data_w, 64'h131);
        @(negedge clk);
        fv = 1'b0;
        #1 check("full_pushpop_held", data_w, 64'h131);
        @(negedge clk);
        rd = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) bus_read("full_rest", 64'h131);
        bus_read("full_tail_a", 64'h161);
        bus_read("full_empty", 64'h0);

        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h29);
        bus_read("ext_space", 64'h120);
        bus_read("ext_empty", 64'h0);

        send(8'h59); send(8'h4D); send(8'h16); send(8'hF0); send(8'h59); send(8'h4D);
        send(8'h5A); send(8'h66);
        bus_read("rshift_P", 64'h150);
        bus_read("shift_digit", 64'h131);
        bus_read("unshift_p", 64'h170);
        bus_read("enter", 64'h10D);
        bus_read("backspace", 64'h108);
        bus_read("misc_empty", 64'h0);

        send(8'hF0);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        send(8'h1C);
        bus_read("reset_prefix", 64'h161);
        bus_read("reset_prefix_empty", 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes complete 11-bit PS/2 frames from the keyboard receiver, validates framing and parity, and tracks make/break/extended prefixes and shift state. Translates a fixed subset of Set-2 scancodes to ASCII and queues the results in a small FIFO. The CPU reads the FIFO through a memory-mapped data/status word on the shared 64-bit bus. Sits directly downstream of the keyboard receiver and upstream of the CPU data bus.

## Interface
- `KBD_ADDRESS`, 14'h2500, bus address of the data/status word
- `FIFO_DEPTH`, 8, ASCII FIFO entries (power of two, ≥2)
- `system_clk`  in  1  sole clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `frame_valid`  in  1  one-cycle strobe, `frame` holds a complete received frame
- `frame`  in  11  `{stop, parity, d7..d0, start}`; bit 0 is the start bit
- `address`  in  14  bus address
- `read`  in  1  bus read enable (level)
- `data`  out  64  `{53'b0, frame_err, overflow, valid, ascii[7:0]}` when `address==KBD_ADDRESS && read`, else 64'bz

## Operation
- Frame check: accept only if `frame[0]==0`, `frame[10]==1`, and `^frame[9:1]==1` (odd parity). A failed frame sets sticky `frame_err`, returns the FSM to IDLE, and is otherwise discarded. `shift` is unchanged.
- Accepted byte `b = frame[8:1]`. FSM states:
  - IDLE: `b==F0`→BREAK; `b==E0`→EXT; `b∈{12,59}`→`shift<=1`; mapped `b`→push ASCII; anything else ignored.
  - BREAK: `b∈{12,59}`→`shift<=0`; any `b`→IDLE, no push.
  - EXT: `b==F0`→EXT_BREAK; else→IDLE, no push (extended keys unmapped).
  - EXT_BREAK: any `b`→IDLE, no push.
- Map, lowercase, or uppercase (ASCII−0x20) when `shift==1`, letters only:
  - a1C b32 c21 d23 e24 f2B g34 h33 i43 j3B k42 l4B m3A n31 o44 p4D q15 r2D s1B t2C u3C v2A w1D x22 y35 z1A
- Digits (shift-independent): 0:45 1:16 2:1E 3:26 4:25 5:2E 6:36 7:3D 8:3E 9:46
- Other keys: space 29→0x20, enter 5A→0x0D, backspace 66→0x08.
- FIFO: circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1.
  - `valid = (count!=0)`; `ascii` = head entry, or 8'h00 when empty.
- Pop: on the first cycle of a matching read. Use a registered `read_hit` to edge-detect `address==KBD_ADDRESS && read`. Empty FIFO: no pop, no pointer change.
  - The same edge clears `overflow` and `frame_err`, after the bus has sampled them that cycle.
- Push while full: entry dropped, `overflow<=1`.
- Push and pop in the same cycle:
  - Both occur, count unchanged. When full, the pop frees a slot and the push succeeds with no overflow.
  - When empty, the push succeeds and the pop is suppressed.
- Set beats clear: a sticky flag set in the same cycle as a clearing read stays 1.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (async assert, sync-safe deassert):
  - FSM=IDLE, shift=0, pointers/count=0, overflow=0, frame_err=0, read_hit=0.
  - `data` reads as 64'h0 when addressed, else high-Z.
- Decode latency: `frame_valid` sampled high at edge k → entry written and count updated at edge k; visible on `data` from k onward (combinational from FIFO head).
- `frame_valid` high on consecutive cycles is legal; each cycle is one frame.
- Bus read: `data` combinational from `address`/`read`; pop at the rising edge ending the first matching cycle. A held read does not pop again until `read` or the address match drops for ≥1 cycle.
- Reset mid-prefix (e.g. after F0) discards the prefix; the next byte is decoded from IDLE.

## Test plan
- Frames 1C, F0, 1C (valid parity) → one entry; read returns 64'h161 (valid=1, 'a'); second read returns 64'h0.
- Frames 12, 1C, F0 1C, F0 12, 1C → reads return 0x41 ('A') then 0x61 ('a'); FIFO then empty.
- Frame with parity bit flipped for 1C → no entry; read returns 64'h400 (frame_err); next read returns 64'h0.
- 9 make codes 16 with FIFO_DEPTH=8 → 8 entries of 0x31, overflow=1 on first read (64'h331). Remaining 7 reads are 64'h131, then empty.
- FIFO full, `frame_valid` and read edge in same cycle → count stays 8, overflow=0, new entry appears last.
- E0 75, E0 F0 75, then 29 → only 0x20 queued. Assert `reset` after a lone F0, then 1C → entry 0x61.
